dircc_gals_receive_scheduler: RTL

//  Shares one device receive handler among N_PORTS inbound packet sources (fabric links/edges).

---
 rtl/dircc_types_pkg.sv | 19 +
 rtl/dircc_rr_arbiter.sv | 30 +++
 rtl/dircc_gals_receive_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dircc_types_pkg.sv
// Shared types for the DIRCC GALS device: packet payload and receive-scheduler FSM encoding.
package dircc_types_pkg;

   typedef struct packed {
      logic [15:0] dst_dev;
      logic [15:0] src_dev;
      logic [31:0] payload;
   } packet_data_t;

   typedef enum logic [1:0] {
      RXS_IDLE     = 2'd0,
      RXS_DISPATCH = 2'd1,
      RXS_WAIT     = 2'd2,
      RXS_COMMIT   = 2'd3
   } rx_sched_state_t;

   localparam int STAT_W = 32;

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins.
// Purely combinational so the same block serves the receive and send schedulers.
module dircc_rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/dircc_gals_receive_scheduler.sv
// Shares one receive handler among N_PORTS inbound sources: RR grant, dispatch, wait, commit.
// Optional DIRCC_RECV_STATS_EN adds saturating packet and stall counters.
module dircc_gals_receive_scheduler
   import dircc_types_pkg::*;
#(
   parameter int N_PORTS        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_PORTS-1:0]            req_valid,
   input  packet_data_t [N_PORTS-1:0]    req_packet,
   input  logic [N_PORTS-1:0][7:0]       req_edge_id,
   input  logic [N_PORTS-1:0][7:0]       req_port_id,
   output logic [N_PORTS-1:0]            req_ready,
   input  logic                          dev_stopped,
   output logic                          hdl_receive_done,
   output packet_data_t                  hdl_packet,
   output logic [7:0]                    hdl_edge_id,
   output logic [7:0]                    hdl_port_id,
   input  logic                          hdl_packet_handled,
   output logic                          state_commit,
   output logic                          send_inhibit,
   output logic                          err_timeout,
`ifdef DIRCC_RECV_STATS_EN
   output logic [STAT_W-1:0]             stat_pkts,
   output logic [STAT_W-1:0]             stat_stall_cycles,
`endif
   output rx_sched_state_t               dbg_state
);

   localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   rx_sched_state_t state_q, state_d;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   gidx_q;
   logic [CW-1:0]   tmo_cnt_q;
   logic [N_PORTS-1:0] arb_grant;
   logic [IW-1:0]   arb_idx;
   logic            arb_valid;
   logic            accept;
   logic            timeout_hit;
   logic [IW-1:0]   rr_next;

   dircc_rr_arbiter #(.N(N_PORTS)) u_arb (
      .req         (req_valid),
      .ptr         (rr_ptr_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign rr_next = (gidx_q == IW'(N_PORTS - 1)) ? '0 : gidx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      req_ready   = '0;
      accept      = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         RXS_IDLE: begin
            // reset also gates the grant so nothing looks accepted while held in reset
            if (!reset && !dev_stopped && arb_valid) begin
               accept    = 1'b1;
               req_ready = arb_grant;
               state_d   = RXS_DISPATCH;
            end
         end
         RXS_DISPATCH: state_d = RXS_WAIT;
         RXS_WAIT: begin
            if (hdl_packet_handled) begin
               state_d = RXS_COMMIT;
            end else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_d     = RXS_IDLE;
            end
         end
         RXS_COMMIT: state_d = RXS_IDLE;
         default:    state_d = RXS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RXS_IDLE;
         rr_ptr_q    <= '0;
         gidx_q      <= '0;
         tmo_cnt_q   <= '0;
         err_timeout <= 1'b0;
         hdl_packet  <= '0;
         hdl_edge_id <= '0;
         hdl_port_id <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            gidx_q      <= arb_idx;
            hdl_packet  <= req_packet[arb_idx];
            hdl_edge_id <= req_edge_id[arb_idx];
            hdl_port_id <= req_port_id[arb_idx];
         end
         if (state_q == RXS_DISPATCH) begin
            tmo_cnt_q <= '0;
         end else if (state_q == RXS_WAIT && !hdl_packet_handled && !timeout_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
         end
         // an aborted source still yields its turn so it cannot starve the others
         if (state_q == RXS_COMMIT || timeout_hit) begin
            rr_ptr_q <= rr_next;
         end
         if (timeout_hit) begin
            err_timeout <= 1'b1;
         end
      end
   end

   assign hdl_receive_done = (state_q == RXS_DISPATCH);
   assign state_commit     = (state_q == RXS_COMMIT);
   assign send_inhibit     = (state_q != RXS_IDLE);
   assign dbg_state        = state_q;

`ifdef DIRCC_RECV_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_pkts         <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (state_q == RXS_COMMIT && stat_pkts != '1) begin
            stat_pkts <= stat_pkts + 1'b1;
         end
         if (|req_valid && state_q != RXS_IDLE && stat_stall_cycles != '1) begin
            stat_stall_cycles <= stat_stall_cycles + 1'b1;
         end
      end
   end
`endif

endmodule
